// File: rtl/alu_core.sv
// Registered 16-function integer ALU with carry/borrow/flag output; 1-cycle latency.
// No handshake or backpressure: a new operation is accepted on every rising edge.
module alu_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_sel,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Carry_out
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res;
   logic               cry;

   assign sum  = {1'b0, A} + {1'b0, B};
   // Top bit of the extended difference is the borrow (set iff A < B).
   assign diff = {1'b0, A} - {1'b0, B};
   assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   always_comb begin
      res = '0;
      cry = 1'b0;
      case (ALU_sel)
         4'd0: begin
            res = sum[WIDTH-1:0];
            cry = sum[WIDTH];
         end
         4'd1: begin
            res = diff[WIDTH-1:0];
            cry = diff[WIDTH];
         end
         4'd2: begin
            res = prod[WIDTH-1:0];
            cry = |prod[2*WIDTH-1:WIDTH];
         end
         4'd3: begin
            // Divide-by-zero saturates to all ones and raises the flag.
            if (B == '0) begin
               res = '1;
               cry = 1'b1;
            end else begin
               res = A / B;
            end
         end
         4'd4: begin
            res = {A[WIDTH-2:0], 1'b0};
            cry = A[WIDTH-1];
         end
         4'd5: begin
            res = {1'b0, A[WIDTH-1:1]};
            cry = A[0];
         end
         4'd6:  res = {A[WIDTH-2:0], A[WIDTH-1]};
         4'd7:  res = {A[0], A[WIDTH-1:1]};
         4'd8:  res = A & B;
         4'd9:  res = A | B;
         4'd10: res = A ^ B;
         4'd11: res = ~(A | B);
         4'd12: res = ~(A & B);
         4'd13: res = ~(A ^ B);
         4'd14: res = {{(WIDTH-1){1'b0}}, (A > B)};
         4'd15: res = {{(WIDTH-1){1'b0}}, (A == B)};
         default: begin
            res = '0;
            cry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ALU_out   <= '0;
         Carry_out <= 1'b0;
      end else begin
         ALU_out   <= res;
         Carry_out <= cry;
      end
   end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected {carry,result} queued at issue, compared after the edge.
module tb_alu_core;

   logic       clk;
   logic       clk_en;
   logic       rst;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] ALU_sel;
   logic [7:0] ALU_out;
   logic       Carry_out;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [8:0] last_exp;

   alu_core #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .A        (A),
      .B        (B),
      .ALU_sel  (ALU_sel),
      .ALU_out  (ALU_out),
      .Carry_out(Carry_out)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got c=%0b r=%02h, want c=%0b r=%02h",
                  tag, got[8], got[7:0], want[8], want[7:0]);
      end
   endtask

   // Independent reference computed with integer arithmetic.
   function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] s);
      int ia, ib, t;
      logic [8:0] r;
      ia = int'(a);
      ib = int'(b);
      r  = 9'h000;
      case (s)
         4'd0: begin t = ia + ib; r = {t > 255, t[7:0]}; end
         4'd1: begin t = (ia - ib + 256) % 256; r = {ia < ib, t[7:0]}; end
         4'd2: begin t = ia * ib; r = {t > 255, t[7:0]}; end
         4'd3: begin
            if (ib == 0) r = 9'h1FF;
            else begin t = ia / ib; r = {1'b0, t[7:0]}; end
         end
         4'd4: begin t = (ia * 2) % 256; r = {ia >= 128, t[7:0]}; end
         4'd5: begin t = ia / 2; r = {(ia % 2) == 1, t[7:0]}; end
         4'd6: begin t = (ia * 2) % 256 + ia / 128; r = {1'b0, t[7:0]}; end
         4'd7: begin t = ia / 2 + (ia % 2) * 128; r = {1'b0, t[7:0]}; end
         4'd8:  r = {1'b0, a & b};
         4'd9:  r = {1'b0, a | b};
         4'd10: r = {1'b0, a ^ b};
         4'd11: r = {1'b0, ~(a | b)};
         4'd12: r = {1'b0, ~(a & b)};
         4'd13: r = {1'b0, ~(a ^ b)};
         4'd14: r = {1'b0, 7'd0, ia > ib};
         default: r = {1'b0, 7'd0, ia == ib};
      endcase
      return r;
   endfunction

   // Drive one op; output must hold its old value until the edge, then show the new one.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                        input logic [8:0] want, input string tag);
      logic [8:0] e;
      A       = a;
      B       = b;
      ALU_sel = s;
      exp_q.push_back(want);
      #1;
      chk({tag, "_pre"}, {Carry_out, ALU_out}, last_exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk(tag, {Carry_out, ALU_out}, e);
      last_exp = e;
   endtask

   task automatic issue_rand(input logic [3:0] s, input string tag);
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) b = 8'h00;
      issue(a, b, s, ref_alu(a, b, s), tag);
   endtask

   initial begin
      clk_en   = 1'b0;
      rst      = 1'b0;
      A        = 8'hFF;
      B        = 8'hFF;
      ALU_sel  = 4'd0;
      last_exp = 9'h000;

      #1 rst = 1'b1;
      #2;
      chk("reset_noclk", {Carry_out, ALU_out}, 9'h000);
      clk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", {Carry_out, ALU_out}, 9'h000);
      @(negedge clk);
      rst = 1'b0;

      issue(8'h10, 8'h20, 4'd0,  9'h030, "add");
      issue(8'hFF, 8'h01, 4'd0,  9'h100, "add_carry");
      issue(8'h05, 8'h07, 4'd1,  9'h1FE, "sub_borrow");
      issue(8'h09, 8'h03, 4'd14, 9'h001, "gt");
      issue(8'h5A, 8'h5A, 4'd15, 9'h001, "eq");
      issue(8'h10, 8'h10, 4'd2,  9'h100, "mul_ovf");
      issue(8'h64, 8'h07, 4'd3,  9'h00E, "div");
      issue(8'h64, 8'h00, 4'd3,  9'h1FF, "div_zero");
      issue(8'h81, 8'h0F, 4'd4,  9'h102, "shl");
      issue(8'h81, 8'h0F, 4'd5,  9'h140, "shr");
      issue(8'h81, 8'h0F, 4'd6,  9'h003, "rol");
      issue(8'h81, 8'h0F, 4'd7,  9'h0C0, "ror");
      issue(8'h81, 8'h0F, 4'd8,  9'h001, "and");
      issue(8'h81, 8'h0F, 4'd9,  9'h08F, "or");
      issue(8'h81, 8'h0F, 4'd10, 9'h08E, "xor");
      issue(8'h81, 8'h0F, 4'd11, 9'h070, "nor");
      issue(8'h81, 8'h0F, 4'd12, 9'h0FE, "nand");
      issue(8'h81, 8'h0F, 4'd13, 9'h071, "xnor");
      issue(8'h03, 8'h09, 4'd14, 9'h000, "gt_false");
      issue(8'h5A, 8'h5B, 4'd15, 9'h000, "eq_false");

      for (int i = 0; i < 16; i++) issue_rand(4'(i), "b2b");

      // Mid-stream reset: in-flight op is dropped, outputs clear without an edge.
      A       = 8'hFF;
      B       = 8'hFF;
      ALU_sel = 4'd0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_async", {Carry_out, ALU_out}, 9'h000);
      @(posedge clk);
      #1;
      chk("rst_mid_hold", {Carry_out, ALU_out}, 9'h000);
      @(negedge clk);
      rst      = 1'b0;
      last_exp = 9'h000;

      issue(8'h10, 8'h20, 4'd0, 9'h030, "post_rst_first");
      for (int rep = 0; rep < 3; rep++)
         for (int i = 15; i >= 0; i--) issue_rand(4'(i), "b2b_rev");

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
